result_writeback: RTL

- Consumer side of the matrix-multiplier compute loop.
- Accepts one PE result per `res_valid` pulse and buffers it in a small FIFO.
- Commits buffered results to result memory in row-major order over a req/ack handshake.
- Drives the `fifo_full` back-pressure that the iteration controller consumes, and flags completion after N*M committed writes.

---
 rtl/matmul_wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/result_writeback.sv | 136 +++++++++++++
 3 files changed

// File: rtl/matmul_wb_pkg.sv
// Shared types and helpers for the matrix-multiplier result write-back path.
package matmul_wb_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_ACK, DONE} wb_state_t;

  // Row-major address of element (n,m).
  function automatic int unsigned addr_of(int unsigned base, int unsigned cols,
                                          int unsigned n, int unsigned m);
    return base + n * cols + m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular result FIFO; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/result_writeback.sv
// Buffers PE results and commits them row-major to result memory over req/ack.
// Optional row markers (row_done/row_idx) are built when WB_ROW_MARK_EN is defined.
module result_writeback
  import matmul_wb_pkg::*;
#(
  parameter int N         = 4,
  parameter int M         = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              fifo_full,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              wb_done,
  output logic              err
`ifdef WB_ROW_MARK_EN
  ,
  output logic              row_done,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] row_idx
`endif
);
  localparam int TOTAL = N * M;
  localparam int CNT_W = $clog2(N * M + 1);
  localparam int FCW   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR0 = ADDR_W'(addr_of(BASE_ADDR, M, 0, 0));

  wb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic [FCW-1:0]    fifo_count;
  logic              f_full, f_empty;
  logic              start_ok, accepting, push, pop, drop, acked, last;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign accepting = (state == ACTIVE) || (state == WAIT_ACK);
  assign push      = res_valid && accepting && !f_full;
  assign drop      = res_valid && !push;
  assign pop       = (state == ACTIVE) && !f_empty;
  assign acked     = (state == WAIT_ACK) && mem_req && mem_ack;
  assign last      = (wr_cnt == CNT_W'(TOTAL - 1));
  assign fifo_full = (fifo_count == FCW'(DEPTH));

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clr   (start_ok),
    .din   (res_data),
    .dout  (fifo_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)   state_nxt = ACTIVE;
      ACTIVE:     if (!f_empty) state_nxt = WAIT_ACK;
      WAIT_ACK:   if (acked)   state_nxt = last ? DONE : ACTIVE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= ADDR0;
      mem_wdata <= '0;
      wr_cnt    <= '0;
      wb_done   <= 1'b0;
      err       <= 1'b0;
    end else if (start_ok) begin
      mem_addr <= ADDR0;
      wr_cnt   <= '0;
      wb_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (drop) err <= 1'b1;
      if (pop) begin
        mem_wdata <= fifo_dout;
        mem_req   <= 1'b1;
      end
      if (acked) begin
        mem_req  <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(1);
        wr_cnt   <= wr_cnt + CNT_W'(1);
        if (last) wb_done <= 1'b1;
      end
    end
  end

`ifdef WB_ROW_MARK_EN
  localparam int MC_W = (M > 1) ? $clog2(M) : 1;
  localparam int NR_W = (N > 1) ? $clog2(N) : 1;

  logic [MC_W-1:0] col;
  logic [NR_W-1:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start_ok) begin
      col <= '0;
      row <= '0;
    end else if (acked) begin
      if (col == MC_W'(M - 1)) begin
        col <= '0;
        row <= row + NR_W'(1);
      end else begin
        col <= col + MC_W'(1);
      end
    end
  end

  assign row_done = acked && (col == MC_W'(M - 1));
  assign row_idx  = row;
`endif

endmodule
